hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the decode stage. It tracks outstanding load destinations in a 32-entry scoreboard and detects load-use RAW hazards against the instruction entering decode. It also runs the data-memory request/ready handshake and sequences control-flow redirects. It drives the decode stage's `stall` input, a bubble (NOP-insert) request, a fetch hold and a fetch flush, and sits beside the decode register between fetch and EX.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: cycles of flush/bubble after a redirect (legal 1..15).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `dec_valid` in 1: a valid instruction is at the decode input.
- `dec_rs1`, `dec_rs2` in 5 each: source addresses of that instruction.
- `dec_use_rs1`, `dec_use_rs2` in 1 each: the instruction reads that source.
- `iss_valid` in 1: the decode output register holds a real instruction entering EX this cycle.
- `iss_rd` in 5: destination of the issuing instruction.
- `iss_reg_write`, `iss_mem_read`, `iss_mem_write` in 1 each: control bits of the issuing instruction.
- `wb_valid` in 1: a load result is written back this cycle.
- `wb_rd` in 5: destination of that load result.
- `mem_req` out 1: data-memory request, registered.
- `mem_ready` in 1: memory completes the current request.
- `redirect` in 1: a taken jump/branch resolved in EX.
- `stall_fetch` out 1: hold the PC and the fetch register.
- `stall_dec` out 1: drives the decode `stall` input (hold the decode outputs).
- `bubble` out 1: the decode output register loads a NOP (`reg_write`=0, `mem_read`/`mem_write`=0).
- `flush` out 1: kill the instruction in fetch.
- `busy_mask` out 32: scoreboard contents; bit 0 is always 0.

## Operation
- Scoreboard:
  - `busy[iss_rd]` sets on `iss_valid & iss_mem_read & iss_reg_write & iss_rd!=0`, gated by `!stall_dec`.
  - `busy[wb_rd]` clears on `wb_valid`.
  - If set and clear hit the same rd in the same cycle, set wins.
- Hazard, combinational: `hz = dec_valid & ((dec_use_rs1 & pend[dec_rs1]) | (dec_use_rs2 & pend[dec_rs2]))`.
  - `pend[r]` = `busy[r]` OR (an issuing load targets r this cycle), AND NOT (`wb_valid & wb_rd==r`, see Configuration).
  - A source of x0 never hazards.
- FSM states: IDLE, MEM, FLUSH.
  - IDLE → MEM on `iss_valid & (iss_mem_read|iss_mem_write)`; `mem_req` goes to 1 the next cycle.
  - In MEM, `mem_req` holds at 1 until the cycle `mem_ready`=1. The next state is FLUSH if `redir_pend`, else IDLE.
  - IDLE → FLUSH on `redirect`; the counter loads `FLUSH_CYCLES-1`.
  - In FLUSH, the counter decrements each cycle and the FSM returns to IDLE after the cycle in which it is 0.
  - `redirect` during MEM sets `redir_pend`, which clears on entry to FLUSH.
  - `redirect` during FLUSH reloads the counter.
  - A memory issue in the same cycle as `redirect` in IDLE goes to MEM, with `redir_pend` set.
- Output priority:
  - MEM & !mem_ready: `stall_fetch`=1, `stall_dec`=1, `bubble`=0, `flush`=0.
  - FLUSH: `flush`=1, `bubble`=1, `stall_fetch`=0, `stall_dec`=0.
  - `hz`: `stall_fetch`=1, `bubble`=1, `stall_dec`=0.
  - Otherwise all outputs 0.
- `mem_ready` outside MEM is ignored.
- `wb_valid` to a non-busy register is a no-op.

## Timing
- Reset (`rst`=0, asynchronous):
  - FSM to IDLE; `busy`=0, counter=0, `redir_pend`=0.
  - `mem_req`=0, `stall_fetch`=0, `stall_dec`=0, `bubble`=0, `flush`=0, `busy_mask`=0.
  - Reset mid-MEM drops `mem_req` immediately; the memory side must tolerate an abandoned request.
- Stall, bubble and flush are combinational from the current state and inputs; they are valid in the same cycle.
- Load-use:
  - A dependent instruction directly behind a load sees `hz` from the issue cycle.
  - It stays stalled until the writeback cycle: with `HZ_WB_BYPASS_EN`, decode releases in that cycle; without it, one cycle later.
- Memory:
  - `mem_req` rises 1 cycle after issue.
  - Minimum MEM residency is 1 cycle (`mem_ready` in the first MEM cycle); `stall_dec` is then 0 in that cycle.
- Redirect: `flush`/`bubble` high for exactly `FLUSH_CYCLES` consecutive cycles, starting the cycle after `redirect`, or the cycle after `mem_ready` if the redirect was pending.

## Configuration
- `HZ_WB_BYPASS_EN` defined:
  - A same-cycle writeback to r masks `pend[r]`.
  - The register file is write-first, so the dependent instruction proceeds in the writeback cycle.
- Not defined:
  - `pend` ignores `wb_*`; the hazard uses registered `busy` only.
  - One extra stall cycle per load-use.
  - The register file may be read-before-write.

## Test plan
- Load x5 issues, next instruction reads rs1=x5, `wb_valid`/`wb_rd`=5 three cycles later:
  - `stall_fetch`=`bubble`=1 for 3 cycles with the bypass, 4 without.
  - `busy_mask` bit 5 goes 1 then 0.
- Load to x0, dependent instruction reads x0: `busy_mask`=0, no stall.
- Store issues, `mem_ready` after 4 MEM cycles:
  - `mem_req` high for 4 cycles.
  - `stall_dec`=`stall_fetch`=1 for 3 cycles, 0 in the ready cycle.
  - FSM back to IDLE.
- `redirect` in IDLE with `FLUSH_CYCLES`=2: `flush`=`bubble`=1 for exactly 2 cycles.
- `redirect` during MEM (`mem_ready` 2 cycles later): no flush during MEM; FLUSH for 2 cycles right after ready.
- `rst` asserted in MEM with `busy_mask`=0x20: all outputs 0 immediately; after release, IDLE with `busy_mask`=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage sequencing controller.
// Tracks outstanding load destinations, detects load-use hazards, runs the
// data-memory request/ready handshake and sequences redirect flushes.
// Optional build macro: HZ_WB_BYPASS_EN. When it is defined, a writeback in
// the current cycle masks the hazard for that register, which requires a
// write-first register file.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no memory access or flush in progress
// S_MEM   | data-memory request outstanding, waiting for i_mem_ready
// S_FLUSH | killing fetch and bubbling decode after a redirect
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,           // asynchronous, active low
  input  logic        i_dec_valid,
  input  logic [4:0]  i_dec_rs1,
  input  logic [4:0]  i_dec_rs2,
  input  logic        i_dec_use_rs1,
  input  logic        i_dec_use_rs2,
  input  logic        i_iss_valid,
  input  logic [4:0]  i_iss_rd,
  input  logic        i_iss_reg_write,
  input  logic        i_iss_mem_read,
  input  logic        i_iss_mem_write,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  output logic        o_mem_req,
  input  logic        i_mem_ready,
  input  logic        i_redirect,
  output logic        o_stall_fetch,
  output logic        o_stall_dec,
  output logic        o_bubble,
  output logic        o_flush,
  output logic [31:0] o_busy_mask
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MEM   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_redir_pend, w_redir_pend_nxt;
  logic        r_mem_req;
  logic [31:0] r_busy, w_busy_nxt;

  logic        w_mem_wait;
  logic        w_mem_issue;
  logic        w_load_issue;
  logic [31:0] w_set_vec;
  logic [31:0] w_clr_vec;
  logic [31:0] w_pend;
  logic        w_hz;

  // Decode is held while a request waits, so nothing issues in those cycles.
  assign w_mem_wait   = (r_state == S_MEM) & ~i_mem_ready;
  assign w_mem_issue  = i_iss_valid & (i_iss_mem_read | i_iss_mem_write);
  assign w_load_issue = i_iss_valid & i_iss_mem_read & i_iss_reg_write &
                        (i_iss_rd != 5'd0) & ~w_mem_wait;

  assign w_set_vec = w_load_issue ? (32'd1 << i_iss_rd) : 32'd0;
  assign w_clr_vec = i_wb_valid   ? (32'd1 << i_wb_rd)  : 32'd0;

  // Set is applied after clear so a same-cycle set/clear on one rd keeps it busy.
  assign w_busy_nxt = ((r_busy & ~w_clr_vec) | w_set_vec) & 32'hFFFF_FFFE;

`ifdef HZ_WB_BYPASS_EN
  assign w_pend = (r_busy | w_set_vec) & ~w_clr_vec & 32'hFFFF_FFFE;
`else
  assign w_pend = (r_busy | w_set_vec) & 32'hFFFF_FFFE;
`endif

  assign w_hz = i_dec_valid & ((i_dec_use_rs1 & w_pend[i_dec_rs1]) |
                               (i_dec_use_rs2 & w_pend[i_dec_rs2]));

  // State, counter, scoreboard and request registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_redir_pend <= 1'b0;
      r_mem_req    <= 1'b0;
      r_busy       <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_redir_pend <= w_redir_pend_nxt;
      r_mem_req    <= (w_state_nxt == S_MEM);
      r_busy       <= w_busy_nxt;
    end
  end

  // Next state and the prioritised stall/bubble/flush outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_redir_pend_nxt = r_redir_pend;
    o_stall_fetch    = 1'b0;
    o_stall_dec      = 1'b0;
    o_bubble         = 1'b0;
    o_flush          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_mem_issue) begin
          w_state_nxt      = S_MEM;
          w_redir_pend_nxt = i_redirect;
        end else if (i_redirect) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      S_MEM: begin
        if (i_mem_ready) begin
          // A redirect landing in the ready cycle is treated as pending too.
          if (r_redir_pend | i_redirect) begin
            w_state_nxt      = S_FLUSH;
            w_cnt_nxt        = CNT_LOAD;
            w_redir_pend_nxt = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (i_redirect) begin
          w_redir_pend_nxt = 1'b1;
        end
      end
      S_FLUSH: begin
        if (i_redirect) begin
          w_cnt_nxt = CNT_LOAD;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_mem_wait) begin
      o_stall_fetch = 1'b1;
      o_stall_dec   = 1'b1;
    end else if (r_state == S_FLUSH) begin
      o_flush  = 1'b1;
      o_bubble = 1'b1;
    end else if (w_hz) begin
      o_stall_fetch = 1'b1;
      o_bubble      = 1'b1;
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_busy_mask = r_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed cycle table, hand-written multi-cycle
// sequences, then random stimulus against a behavioural model.
module tb_hazard_ctrl;

  localparam int F = 2;
`ifdef HZ_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        dec_valid, dec_use_rs1, dec_use_rs2;
  logic [4:0]  dec_rs1, dec_rs2;
  logic        iss_valid, iss_reg_write, iss_mem_read, iss_mem_write;
  logic [4:0]  iss_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        mem_ready, redirect;
  logic        o_mem_req, o_stall_fetch, o_stall_dec, o_bubble, o_flush;
  logic [31:0] o_busy_mask;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.FLUSH_CYCLES(F)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_dec_valid(dec_valid), .i_dec_rs1(dec_rs1), .i_dec_rs2(dec_rs2),
    .i_dec_use_rs1(dec_use_rs1), .i_dec_use_rs2(dec_use_rs2),
    .i_iss_valid(iss_valid), .i_iss_rd(iss_rd),
    .i_iss_reg_write(iss_reg_write), .i_iss_mem_read(iss_mem_read),
    .i_iss_mem_write(iss_mem_write),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
    .o_mem_req(o_mem_req), .i_mem_ready(mem_ready), .i_redirect(redirect),
    .o_stall_fetch(o_stall_fetch), .o_stall_dec(o_stall_dec),
    .o_bubble(o_bubble), .o_flush(o_flush), .o_busy_mask(o_busy_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       dv;  logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
    logic       iv;  logic [4:0] rd;  logic rw; logic mr; logic mw;
    logic       wv;  logic [4:0] wrd; logic rdy; logic redir;
    logic [36:0] exp_o;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [36:0] ex(input logic req, sf, sd, bub, fl,
                                     input logic [31:0] b);
    return {req, sf, sd, bub, fl, b};
  endfunction

  function automatic vec_t mk(input logic dv, input logic [4:0] rs1, rs2,
                              input logic u1, u2, iv, input logic [4:0] rd,
                              input logic rw, mr, mw, wv, input logic [4:0] wrd,
                              input logic rdy, redir, input logic [36:0] e);
    vec_t v;
    v.dv = dv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.iv = iv; v.rd = rd; v.rw = rw; v.mr = mr; v.mw = mw;
    v.wv = wv; v.wrd = wrd; v.rdy = rdy; v.redir = redir; v.exp_o = e;
    return v;
  endfunction

  function automatic logic [36:0] dut_o();
    return {o_mem_req, o_stall_fetch, o_stall_dec, o_bubble, o_flush, o_busy_mask};
  endfunction

  task automatic drv(input vec_t v);
    dec_valid = v.dv; dec_rs1 = v.rs1; dec_rs2 = v.rs2;
    dec_use_rs1 = v.u1; dec_use_rs2 = v.u2;
    iss_valid = v.iv; iss_rd = v.rd; iss_reg_write = v.rw;
    iss_mem_read = v.mr; iss_mem_write = v.mw;
    wb_valid = v.wv; wb_rd = v.wrd; mem_ready = v.rdy; redirect = v.redir;
  endtask

  task automatic quiet();
    drv(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, '0));
  endtask

  // Output vector layout: {mem_req, stall_fetch, stall_dec, bubble, flush, busy_mask}
  task automatic chk(input string nm, input logic [36:0] act, input logic [36:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: busy set, remaining flush cycles, memory wait flag.
  bit m_busy[32];
  bit m_in_mem;
  bit m_rpend;
  int m_flush_left;

  task automatic m_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_in_mem = 1'b0; m_rpend = 1'b0; m_flush_left = 0;
  endtask

  function automatic bit m_pend(input logic [4:0] r);
    bit p;
    if (r == 5'd0) return 1'b0;
    p = m_busy[r] || (iss_valid && iss_mem_read && iss_reg_write && iss_rd == r &&
                      !(m_in_mem && !mem_ready));
    if (BYP && wb_valid && wb_rd == r) p = 1'b0;
    return p;
  endfunction

  function automatic logic [36:0] m_expect();
    bit sf, sd, bub, fl, hz;
    logic [31:0] b;
    sf = 0; sd = 0; bub = 0; fl = 0;
    hz = dec_valid && ((dec_use_rs1 && m_pend(dec_rs1)) || (dec_use_rs2 && m_pend(dec_rs2)));
    if (m_in_mem && !mem_ready) begin sf = 1; sd = 1; end
    else if (m_flush_left > 0) begin fl = 1; bub = 1; end
    else if (hz) begin sf = 1; bub = 1; end
    for (int i = 0; i < 32; i++) b[i] = m_busy[i];
    return {m_in_mem, sf, sd, bub, fl, b};
  endfunction

  task automatic m_step();
    bit wait_now;
    wait_now = m_in_mem && !mem_ready;
    if (wb_valid) m_busy[wb_rd] = 1'b0;
    if (iss_valid && iss_mem_read && iss_reg_write && iss_rd != 0 && !wait_now)
      m_busy[iss_rd] = 1'b1;
    if (m_in_mem) begin
      if (mem_ready) begin
        m_in_mem = 1'b0;
        if (m_rpend || redirect) begin m_flush_left = F; m_rpend = 1'b0; end
      end else if (redirect) m_rpend = 1'b1;
    end else if (m_flush_left > 0) begin
      if (redirect) m_flush_left = F;
      else m_flush_left--;
    end else if (iss_valid && (iss_mem_read || iss_mem_write)) begin
      m_in_mem = 1'b1;
      m_rpend = redirect;
    end else if (redirect) m_flush_left = F;
  endtask

  initial begin
    // cycle-by-cycle directed table starting right after reset
    tbl[0]  = mk(1,5,0,1,0, 1,5,1,1,0, 0,0,0,0, ex(0,1,0,1,0, 32'h0));
    tbl[1]  = mk(1,5,0,1,0, 0,0,0,0,0, 0,0,1,0, ex(1,1,0,1,0, 32'h20));
    tbl[2]  = mk(1,5,0,1,0, 0,0,0,0,0, 0,0,0,0, ex(0,1,0,1,0, 32'h20));
    tbl[3]  = mk(1,5,0,1,0, 0,0,0,0,0, 1,5,0,0, ex(0,!BYP,0,!BYP,0, 32'h20));
    tbl[4]  = mk(1,5,0,1,0, 0,0,0,0,0, 0,0,0,0, ex(0,0,0,0,0, 32'h0));
    tbl[5]  = mk(1,0,0,1,1, 1,0,1,1,0, 0,0,0,0, ex(0,0,0,0,0, 32'h0));
    tbl[6]  = mk(1,0,0,1,1, 0,0,0,0,0, 0,0,1,0, ex(1,0,0,0,0, 32'h0));
    tbl[7]  = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, ex(0,0,0,0,0, 32'h0));
    tbl[8]  = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,1, ex(0,0,0,0,0, 32'h0));
    tbl[9]  = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, ex(0,0,0,1,1, 32'h0));
    tbl[10] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, ex(0,0,0,1,1, 32'h0));
    tbl[11] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, ex(0,0,0,0,0, 32'h0));
    tbl[12] = mk(0,0,0,0,0, 1,7,1,1,0, 1,7,0,0, ex(0,0,0,0,0, 32'h0));
    tbl[13] = mk(1,7,3,0,1, 0,0,0,0,0, 0,0,1,0, ex(1,0,0,0,0, 32'h80));
    tbl[14] = mk(1,0,7,0,1, 0,0,0,0,0, 1,7,0,0, ex(0,!BYP,0,!BYP,0, 32'h80));
    tbl[15] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, ex(0,0,0,0,0, 32'h0));

    quiet();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_state", dut_o(), ex(0,0,0,0,0, 32'h0));
    @(negedge clk);
    rst = 1'b1;
    next_cyc();

    for (int i = 0; i < 16; i++) begin
      drv(tbl[i]);
      #2;
      chk($sformatf("table_row%0d", i), dut_o(), tbl[i].exp_o);
      next_cyc();
    end

    // store with four MEM cycles, ready in the fourth
    quiet(); iss_valid = 1; iss_mem_write = 1; iss_rd = 9;
    #2; chk("store_issue", dut_o(), ex(0,0,0,0,0, 32'h0));
    next_cyc();
    quiet();
    for (int k = 1; k <= 3; k++) begin
      #2; chk($sformatf("store_wait%0d", k), dut_o(), ex(1,1,1,0,0, 32'h0));
      next_cyc();
    end
    mem_ready = 1;
    #2; chk("store_ready", dut_o(), ex(1,0,0,0,0, 32'h0));
    next_cyc();
    quiet();
    #2; chk("store_idle", dut_o(), ex(0,0,0,0,0, 32'h0));
    next_cyc();

    // redirect while a request is outstanding
    iss_valid = 1; iss_mem_write = 1;
    #2; chk("rmem_issue", dut_o(), ex(0,0,0,0,0, 32'h0));
    next_cyc();
    quiet(); redirect = 1;
    #2; chk("rmem_redir", dut_o(), ex(1,1,1,0,0, 32'h0));
    next_cyc();
    quiet();
    #2; chk("rmem_wait", dut_o(), ex(1,1,1,0,0, 32'h0));
    next_cyc();
    mem_ready = 1;
    #2; chk("rmem_ready", dut_o(), ex(1,0,0,0,0, 32'h0));
    next_cyc();
    quiet();
    #2; chk("rmem_flush1", dut_o(), ex(0,0,0,1,1, 32'h0));
    next_cyc();
    #2; chk("rmem_flush2", dut_o(), ex(0,0,0,1,1, 32'h0));
    next_cyc();
    #2; chk("rmem_done", dut_o(), ex(0,0,0,0,0, 32'h0));
    next_cyc();

    // asynchronous reset in the middle of a load request
    iss_valid = 1; iss_mem_read = 1; iss_reg_write = 1; iss_rd = 5;
    #2; chk("rst_issue", dut_o(), ex(0,0,0,0,0, 32'h0));
    next_cyc();
    quiet();
    #1; chk("rst_in_mem", dut_o(), ex(1,1,1,0,0, 32'h20));
    rst = 1'b0;
    #1; chk("rst_immediate", dut_o(), ex(0,0,0,0,0, 32'h0));
    next_cyc();
    rst = 1'b1;
    redirect = 1;
    #2; chk("rst_after", dut_o(), ex(0,0,0,0,0, 32'h0));
    next_cyc();
    quiet();
    #2; chk("rst_idle_flush", dut_o(), ex(0,0,0,1,1, 32'h0));
    next_cyc();

    // randomized run against the model
    rst = 1'b0;
    m_reset();
    next_cyc();
    rst = 1'b1;
    next_cyc();
    for (int n = 0; n < 3000; n++) begin
      mem_ready   = ($urandom_range(0, 2) == 0);
      redirect    = ($urandom_range(0, 11) == 0);
      dec_valid   = 1'($urandom_range(0, 1));
      dec_rs1     = 5'($urandom_range(0, 7));
      dec_rs2     = 5'($urandom_range(0, 7));
      dec_use_rs1 = 1'($urandom_range(0, 1));
      dec_use_rs2 = 1'($urandom_range(0, 1));
      iss_valid   = (m_in_mem && !mem_ready) ? 1'b0 : 1'($urandom_range(0, 1));
      iss_rd      = 5'($urandom_range(0, 7));
      iss_reg_write = 1'($urandom_range(0, 1));
      iss_mem_read  = ($urandom_range(0, 2) == 0);
      iss_mem_write = ($urandom_range(0, 3) == 0);
      wb_valid    = ($urandom_range(0, 3) == 0);
      wb_rd       = 5'($urandom_range(0, 7));
      #2;
      chk($sformatf("rand_cyc%0d", n), dut_o(), m_expect());
      m_step();
      next_cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
